// File: rtl/led_arb_pkg.sv
// led_arb_pkg: shared types and helpers for the LED bank arbiter.
package led_arb_pkg;

    typedef enum logic {IDLE, HOLD} state_t;

    // The pointer resets one below NUM_REQ so requester 0 is searched first.
    localparam int LAST_INIT_OFFSET = 1;

    function automatic int cnt_width(input int hold_cycles);
        return (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// led_rr_pick: round-robin search of req starting just after the last winner.
module led_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      winner,
    output logic               any_req
);
    always_comb begin
        int idx;
        idx = 0;
        winner = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k >= NUM_REQ) ? int'(last) + k - NUM_REQ : int'(last) + k;
            if (req[idx]) winner = IW'(idx);
        end
        any_req = |req;
    end
endmodule

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: time-sliced round-robin sharing of the LED bank between requesters.
// Define LED_ARB_IDLE_BLINK_EN to show heartbeat bit HB_BIT on led[0] while idle.
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int LED_W       = 8,
    parameter int HOLD_CYCLES = 1024,
    parameter int HB_BIT      = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] pattern,
    output logic [NUM_REQ-1:0]       grant,
    output logic [LED_W-1:0]         led,
    output logic                     busy
);
    localparam int CW = cnt_width(HOLD_CYCLES);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - LAST_INIT_OFFSET);

    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] last, last_nxt, winner;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [LED_W-1:0] led_nxt, idle_led;
    logic any_req, reload;

    led_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req     (req),
        .last    (last),
        .winner  (winner),
        .any_req (any_req)
    );

`ifdef LED_ARB_IDLE_BLINK_EN
    logic [HB_BIT:0] hb;
    always_ff @(posedge clk) hb <= rst ? '0 : hb + 1'b1;
    assign idle_led = LED_W'(hb[HB_BIT]);
`else
    assign idle_led = '0;
`endif

    assign reload = (state == IDLE) || (cnt == '0);
    assign busy   = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= LAST_INIT;
            grant <= '0;
            led   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
            grant <= grant_nxt;
            led   <= led_nxt;
        end
    end

    always_comb begin
        state_nxt = reload ? (any_req ? HOLD : IDLE) : HOLD;
    end

    always_comb begin
        grant_nxt = reload ? (any_req ? NUM_REQ'(1) << winner : '0) : grant;
        last_nxt  = (reload && any_req) ? winner : last;
        cnt_nxt   = reload ? CW'(HOLD_CYCLES - 1) : cnt - 1'b1;
        led_nxt   = (state_nxt == HOLD) ? pattern[int'(last_nxt)*LED_W +: LED_W] : idle_led;
    end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter: directed checks of the LED bank arbiter with HOLD_CYCLES=8.
module tb_led_bank_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b1111;
    logic [7:0]  p [4] = '{8'h11, 8'hA5, 8'h3C, 8'hF0};
    logic [31:0] pattern;
    logic [3:0]  grant;
    logic [7:0]  led;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    assign pattern = {p[3], p[2], p[1], p[0]};

    led_bank_arbiter #(
        .NUM_REQ(4), .LED_W(8), .HOLD_CYCLES(8), .HB_BIT(3)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .pattern(pattern),
        .grant(grant), .led(led), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset holds everything at zero despite requests
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_grant", 32'(grant), 0);
            chk("rst_led", 32'(led), 0);
            chk("rst_busy", 32'(busy), 0);
        end
        rst = 1'b0;
        // all requesting: four 8-cycle slots in order, wrapping to 0
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(4'b0001 << ((i / 8) % 4)));
            chk("rr_led", 32'(led), 32'(p[(i / 8) % 4]));
            chk("rr_busy", 32'(busy), 1);
        end

        // single requester is re-granted without a gap
        req = 4'b0010;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("solo_grant", 32'(grant), 32'h2);
            chk("solo_led", 32'(led), 32'hA5);
            chk("solo_busy", 32'(busy), 1);
        end

        // one-cycle pulse holds a full slot, pattern change visible next cycle
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) p[2] = 8'h42;
            tick();
            req = 4'b0000;
            chk("pulse_grant", 32'(grant), 32'h4);
            chk("pulse_led", 32'(led), (c >= 3) ? 32'h42 : 32'h3C);
            chk("pulse_busy", 32'(busy), 1);
        end
        tick();
        chk("idle_grant", 32'(grant), 0);
        chk("idle_led", 32'(led), 0);
        chk("idle_busy", 32'(busy), 0);
        p[2] = 8'h3C;

        // late request in owner's final cycle takes over with no blank cycle
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            tick();
            req = 4'b0000;
            chk("own0_grant", 32'(grant), 32'h1);
        end
        req = 4'b1000;
        tick();
        chk("hand_grant", 32'(grant), 32'h8);
        chk("hand_led", 32'(led), 32'hF0);
        chk("hand_busy", 32'(busy), 1);
        req = 4'b0000;
        for (int c = 0; c < 3; c++) tick();
        chk("mid_grant", 32'(grant), 32'h8);
        rst = 1'b1;
        tick();
        chk("abort_grant", 32'(grant), 0);
        chk("abort_led", 32'(led), 0);
        chk("abort_busy", 32'(busy), 0);

        // idle LED: heartbeat bit 3 on led[0] when enabled, otherwise dark
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
`ifdef LED_ARB_IDLE_BLINK_EN
            chk("hb_led", 32'(led), 32'(((k - 1) >> 3) & 1));
`else
            chk("hb_led", 32'(led), 0);
`endif
            chk("hb_grant", 32'(grant), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
